// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with a 3-bit command set
// (push/pop/replace/dup/clear), fill-level flags and a sticky fault code.
module lifo_stack_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 cmd,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       error,
    output logic [1:0]                 err_code
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        CMD_NOOP    = 3'b000,
        CMD_CLEAR   = 3'b001,
        CMD_PUSH    = 3'b010,
        CMD_POP     = 3'b011,
        CMD_REPLACE = 3'b100,
        CMD_DUP     = 3'b101
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    logic push_ok;
    logic pop_ok;
    logic replace_ok;
    logic dup_ok;
    logic clear_req;
    logic fault;
    err_e fault_code;

    // The slot above the top is only addressed while not full, so the
    // truncated count is always a legal index there.
    assign wr_idx  = count[AW-1:0];
    assign top_idx = count[AW-1:0] - AW'(1);

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_CNT);
    assign top         = empty ? '0 : mem[top_idx];

    // Rejection is decided here before any count arithmetic, so a faulting
    // command never touches the array, count or data_out.
    always_comb begin
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        replace_ok = 1'b0;
        dup_ok     = 1'b0;
        clear_req  = 1'b0;
        fault      = 1'b0;
        fault_code = ERR_NONE;
        case (cmd)
            CMD_NOOP: ;
            CMD_CLEAR: clear_req = 1'b1;
            CMD_PUSH: begin
                if (full) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                end else begin
                    push_ok = 1'b1;
                end
            end
            CMD_POP: begin
                if (empty) begin
                    fault      = 1'b1;
                    fault_code = ERR_UNDERFLOW;
                end else begin
                    pop_ok = 1'b1;
                end
            end
            CMD_REPLACE: begin
                if (empty) begin
                    fault      = 1'b1;
                    fault_code = ERR_UNDERFLOW;
                end else begin
                    replace_ok = 1'b1;
                end
            end
            CMD_DUP: begin
                if (empty) begin
                    fault      = 1'b1;
                    fault_code = ERR_UNDERFLOW;
                end else if (full) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                end else begin
                    dup_ok = 1'b1;
                end
            end
            default: begin
                fault      = 1'b1;
                fault_code = ERR_ILLEGAL;
            end
        endcase
    end

    // Array has no reset; entries are discarded by zeroing count instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (push_ok) begin
                mem[wr_idx] <= data_in;
            end else if (dup_ok) begin
                mem[wr_idx] <= mem[top_idx];
            end else if (replace_ok) begin
                mem[top_idx] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            data_out <= '0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            error <= fault;
            if (fault) begin
                err_code <= fault_code;
            end
            if (clear_req) begin
                count    <= '0;
                data_out <= '0;
                err_code <= ERR_NONE;
            end else if (push_ok || dup_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok) begin
                count    <= count - CNT_ONE;
                data_out <= mem[top_idx];
            end
        end
    end

endmodule

// File: doc/lifo_stack_param.md
# lifo_stack_param

Parametrised synchronous LIFO stack, the successor to the fixed 8×8 command-driven stack. It keeps the 2-bit command set and adds three things: configurable width and depth, two extra stack operations (replace-top, duplicate-top), and status outputs for fill level and fault type. It sits between a command/data producer and any consumer that needs last-in-first-out storage, with single-cycle command issue and no handshake.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2)
- AFULL_LVL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- cmd  in  3  command, sampled every rising edge: 000 no_op, 001 clear, 010 push, 011 pop, 100 replace, 101 dup, 110/111 illegal
- data_in  in  WIDTH  push/replace operand
- data_out  out  WIDTH  registered value of the last successful pop
- top  out  WIDTH  current top-of-stack entry; 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- error  out  1  one-cycle pulse flagging a rejected command
- err_code  out  2  cause of the most recent error: 01 overflow, 10 underflow, 11 illegal cmd; 00 after reset/clear

## Operation
- Storage is a DEPTH×WIDTH register array plus a count register. The top entry is mem[count-1].
- push: if not full, mem[count] ← data_in and count+1. If full, the command is an overflow error.
- pop: if not empty, data_out ← mem[count-1] and count-1. If empty, the command is an underflow error.
- replace: if not empty, mem[count-1] ← data_in and count is unchanged. If empty, the command is an underflow error.
- dup: if empty, the command is an underflow error. Otherwise, if full, it is an overflow error. Otherwise mem[count] ← mem[count-1] and count+1.
- clear: count ← 0, data_out ← 0, err_code ← 00, error ← 0. Array contents are not scrubbed.
- no_op: no state change; error deasserts.
- illegal (110/111): no state change; error=1, err_code=11.
- A rejected command changes neither the stack, count, data_out nor top. It sets error=1 for exactly one cycle and loads err_code.
- err_code holds its value until the next error, clear or reset.
- full, empty, almost_full and top are combinational from count and the array, so they are consistent with count at all times.
- Count arithmetic never wraps. Rejection happens before any increment or decrement.

## Timing
- All state updates on the rising clk edge in which cmd is sampled. Each command takes effect with 1-cycle latency and a new command can be issued every cycle.
- data_out is valid in the cycle after a pop edge and holds until the next successful pop, clear or reset.
- top and count reflect the post-edge state in the same cycle as data_out.
- error is high for the single cycle following the offending edge. Back-to-back faulting commands keep it high, and err_code tracks the latest fault.
- Reset (rst_n=0 at an edge) takes priority over cmd. After reset: count=0, empty=1, full=0, almost_full=0 (AFULL_LVL≥1), data_out=0, top=0, error=0, err_code=00.
- Reset in the middle of a sequence discards all entries. cmd is ignored while rst_n=0.
- Stack flags change only on clock edges: nothing is asynchronous except the combinational decode from registers.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AFULL_LVL=7.
- Reset then pop → error pulses one cycle, err_code=10, count=0, data_out=00.
- push 01, push 02, no_op, pop → data_out=02, top=01, count=1, error never set.
- From empty, push 03..0A (8 words), then push 0B → full=1, almost_full asserted at count=7; 9th push gives error=1, err_code=01, top=0A, count=8.
- With stack [01,02,03]: replace 55 → top=55, count=3. Then dup → count=4, top=55. Then pop twice → data_out=55, then 55; top=02.
- cmd=110 with stack [10] → error=1, err_code=11, top=10, count=1. Then clear → count=0, err_code=00, data_out=00. Then push 20 → top=20.
- Push 04 words, assert rst_n=0 together with a push → count=0, empty=1, and the pushed word is not stored. Release reset, pop → underflow error.
